// File: rtl/de_pipe_reg_if.sv
// Decode-to-execute field bundle: decode-side inputs and registered DD-stage outputs.
interface de_pipe_reg_if #(
  parameter int unsigned OP_W = 11,
  parameter int unsigned XLEN = 32
);
  logic            D_valid_i;
  logic [XLEN-1:0] D_pc_i;
  logic [31:0]     D_instr_i;
  logic [OP_W-1:0] D_epcode_i;
  logic [4:0]      D_rs1_i;
  logic [4:0]      D_rs2_i;
  logic [4:0]      D_dstE_i;
  logic            D_need_dstE_i;
  logic [XLEN-1:0] D_imm_i;
  logic [XLEN-1:0] D_rs1_val_i;
  logic [XLEN-1:0] D_rs2_val_i;

  logic            DD_valid_o;
  logic [XLEN-1:0] DD_pc_o;
  logic [31:0]     DD_instr_o;
  logic [OP_W-1:0] DD_epcode_o;
  logic [4:0]      DD_rs1_o;
  logic [4:0]      DD_rs2_o;
  logic [4:0]      DD_dstE_o;
  logic            DD_need_dstE_o;
  logic [XLEN-1:0] DD_imm_o;
  logic [XLEN-1:0] DD_rs1_val_o;
  logic [XLEN-1:0] DD_rs2_val_o;

  // Decode stage side: drives D_* fields, observes DD_* fields.
  modport master (
    output D_valid_i, D_pc_i, D_instr_i, D_epcode_i, D_rs1_i, D_rs2_i,
           D_dstE_i, D_need_dstE_i, D_imm_i, D_rs1_val_i, D_rs2_val_i,
    input  DD_valid_o, DD_pc_o, DD_instr_o, DD_epcode_o, DD_rs1_o, DD_rs2_o,
           DD_dstE_o, DD_need_dstE_o, DD_imm_o, DD_rs1_val_o, DD_rs2_val_o
  );

  // Pipeline register side.
  modport slave (
    input  D_valid_i, D_pc_i, D_instr_i, D_epcode_i, D_rs1_i, D_rs2_i,
           D_dstE_i, D_need_dstE_i, D_imm_i, D_rs1_val_i, D_rs2_val_i,
    output DD_valid_o, DD_pc_o, DD_instr_o, DD_epcode_o, DD_rs1_o, DD_rs2_o,
           DD_dstE_o, DD_need_dstE_o, DD_imm_o, DD_rs1_val_o, DD_rs2_val_o
  );
endinterface

// File: rtl/de_pipe_reg.sv
// Decode-to-execute pipeline register with stall/bubble control and
// per-stage event counters for pipeline-efficiency debug.
module de_pipe_reg #(
  parameter int unsigned OP_W      = 11,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             D_stall_i,
  input  logic             D_bubble_i,
  input  logic             cnt_clr_i,
  de_pipe_reg_if.slave     dp,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] issue_cnt_o
);

  logic load_en;
  assign load_en = !D_bubble_i && !D_stall_i;

  // Bubble outranks stall; stall simply holds every field.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dp.DD_valid_o     <= 1'b0;
      dp.DD_pc_o        <= '0;
      dp.DD_instr_o     <= NOP_INSTR;
      dp.DD_epcode_o    <= '0;
      dp.DD_rs1_o       <= '0;
      dp.DD_rs2_o       <= '0;
      dp.DD_dstE_o      <= '0;
      dp.DD_need_dstE_o <= 1'b0;
      dp.DD_imm_o       <= '0;
      dp.DD_rs1_val_o   <= '0;
      dp.DD_rs2_val_o   <= '0;
    end else if (D_bubble_i) begin
      dp.DD_valid_o     <= 1'b0;
      dp.DD_pc_o        <= '0;
      dp.DD_instr_o     <= NOP_INSTR;
      dp.DD_epcode_o    <= '0;
      dp.DD_rs1_o       <= '0;
      dp.DD_rs2_o       <= '0;
      dp.DD_dstE_o      <= '0;
      dp.DD_need_dstE_o <= 1'b0;
      dp.DD_imm_o       <= '0;
      dp.DD_rs1_val_o   <= '0;
      dp.DD_rs2_val_o   <= '0;
    end else if (!D_stall_i) begin
      dp.DD_valid_o     <= dp.D_valid_i;
      dp.DD_pc_o        <= dp.D_pc_i;
      dp.DD_instr_o     <= dp.D_instr_i;
      // Invalid slots must never look like a hazard source downstream.
      dp.DD_epcode_o    <= dp.D_valid_i ? dp.D_epcode_i : '0;
      dp.DD_need_dstE_o <= dp.D_valid_i & dp.D_need_dstE_i;
      dp.DD_rs1_o       <= dp.D_rs1_i;
      dp.DD_rs2_o       <= dp.D_rs2_i;
      dp.DD_dstE_o      <= dp.D_dstE_i;
      dp.DD_imm_o       <= dp.D_imm_i;
      dp.DD_rs1_val_o   <= dp.D_rs1_val_i;
      dp.DD_rs2_val_o   <= dp.D_rs2_val_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
      issue_cnt_o  <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
      issue_cnt_o  <= '0;
    end else begin
      if (D_stall_i && !D_bubble_i) stall_cnt_o  <= stall_cnt_o + CNT_W'(1);
      if (D_bubble_i)               bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      if (load_en && dp.D_valid_i)  issue_cnt_o  <= issue_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: load, stall, bubble priority, invalid gating,
// async reset mid-stall, counter clear and 4-bit counter wrap.
module tb_de_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  logic stall, bubble, clr;
  logic s_stall, s_bubble, s_clr;
  logic [31:0] stall_cnt, bubble_cnt, issue_cnt;
  logic [3:0]  s_stall_cnt, s_bubble_cnt, s_issue_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de_pipe_reg_if #(.OP_W(11), .XLEN(32)) m_if ();
  de_pipe_reg_if #(.OP_W(11), .XLEN(32)) s_if ();

  de_pipe_reg #(.OP_W(11), .XLEN(32), .CNT_W(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk_i(clk), .rst_i(rst), .D_stall_i(stall), .D_bubble_i(bubble), .cnt_clr_i(clr),
    .dp(m_if.slave),
    .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt), .issue_cnt_o(issue_cnt)
  );

  de_pipe_reg #(.OP_W(11), .XLEN(32), .CNT_W(4), .NOP_INSTR(32'h0000_0013)) dut_small (
    .clk_i(clk), .rst_i(rst), .D_stall_i(s_stall), .D_bubble_i(s_bubble), .cnt_clr_i(s_clr),
    .dp(s_if.slave),
    .stall_cnt_o(s_stall_cnt), .bubble_cnt_o(s_bubble_cnt), .issue_cnt_o(s_issue_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; clr = 1'b0;
    s_stall = 1'b0; s_bubble = 1'b0; s_clr = 1'b0;
    m_if.D_valid_i = 1'b0; m_if.D_pc_i = '0; m_if.D_instr_i = '0; m_if.D_epcode_i = '0;
    m_if.D_rs1_i = '0; m_if.D_rs2_i = '0; m_if.D_dstE_i = '0; m_if.D_need_dstE_i = 1'b0;
    m_if.D_imm_i = '0; m_if.D_rs1_val_i = '0; m_if.D_rs2_val_i = '0;
    s_if.D_valid_i = 1'b0; s_if.D_pc_i = '0; s_if.D_instr_i = '0; s_if.D_epcode_i = '0;
    s_if.D_rs1_i = '0; s_if.D_rs2_i = '0; s_if.D_dstE_i = '0; s_if.D_need_dstE_i = 1'b0;
    s_if.D_imm_i = '0; s_if.D_rs1_val_i = '0; s_if.D_rs2_val_i = '0;

    #2;
    chk("rst_valid", m_if.DD_valid_o, 0);
    chk("rst_instr", m_if.DD_instr_o, 64'h13);
    chk("rst_issue", issue_cnt, 0);
    #10 rst = 1'b0;  // t=12, between edges

    // Load
    m_if.D_valid_i = 1'b1; m_if.D_pc_i = 32'h100; m_if.D_dstE_i = 5'd5;
    m_if.D_need_dstE_i = 1'b1; m_if.D_epcode_i = 11'b000_0000_0100;
    m_if.D_instr_i = 32'h0002_a283; m_if.D_imm_i = 32'h4; m_if.D_rs1_val_i = 32'hdead_beef;
    edge1();
    chk("load_pc", m_if.DD_pc_o, 64'h100);
    chk("load_dst", m_if.DD_dstE_o, 5);
    chk("load_valid", m_if.DD_valid_o, 1);
    chk("load_need", m_if.DD_need_dstE_o, 1);
    chk("load_epcode", m_if.DD_epcode_o, 64'h4);
    chk("load_rs1val", m_if.DD_rs1_val_o, 64'hdead_beef);
    chk("load_issue", issue_cnt, 1);

    // Load-use stall for two cycles
    stall = 1'b1; m_if.D_pc_i = 32'h104; m_if.D_dstE_i = 5'd6;
    edge1();
    chk("stall1_pc", m_if.DD_pc_o, 64'h100);
    chk("stall1_cnt", stall_cnt, 1);
    edge1();
    chk("stall2_pc", m_if.DD_pc_o, 64'h100);
    chk("stall2_dst", m_if.DD_dstE_o, 5);
    chk("stall2_cnt", stall_cnt, 2);
    chk("stall2_issue", issue_cnt, 1);
    stall = 1'b0;
    edge1();
    chk("rel_pc", m_if.DD_pc_o, 64'h104);
    chk("rel_issue", issue_cnt, 2);

    // Bubble beats stall
    stall = 1'b1; bubble = 1'b1;
    edge1();
    chk("bub_valid", m_if.DD_valid_o, 0);
    chk("bub_instr", m_if.DD_instr_o, 64'h13);
    chk("bub_need", m_if.DD_need_dstE_o, 0);
    chk("bub_pc", m_if.DD_pc_o, 0);
    chk("bub_cnt", bubble_cnt, 1);
    chk("bub_stallcnt", stall_cnt, 2);
    chk("bub_issue", issue_cnt, 2);

    // Invalid-input gating
    stall = 1'b0; bubble = 1'b0;
    m_if.D_valid_i = 1'b0; m_if.D_need_dstE_i = 1'b1; m_if.D_epcode_i = 11'b100_0000_0001;
    m_if.D_pc_i = 32'h108; m_if.D_dstE_i = 5'd7;
    edge1();
    chk("inv_need", m_if.DD_need_dstE_o, 0);
    chk("inv_epcode", m_if.DD_epcode_o, 0);
    chk("inv_valid", m_if.DD_valid_o, 0);
    chk("inv_pc", m_if.DD_pc_o, 64'h108);
    chk("inv_dst", m_if.DD_dstE_o, 7);
    chk("inv_issue", issue_cnt, 2);

    // Async reset mid-stall
    m_if.D_valid_i = 1'b1; m_if.D_pc_i = 32'h10c; m_if.D_epcode_i = 11'b000_0000_0100;
    edge1();
    chk("pre_pc", m_if.DD_pc_o, 64'h10c);
    chk("pre_issue", issue_cnt, 3);
    stall = 1'b1;
    edge1();
    chk("pre_stallcnt", stall_cnt, 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", m_if.DD_valid_o, 0);
    chk("arst_pc", m_if.DD_pc_o, 0);
    chk("arst_instr", m_if.DD_instr_o, 64'h13);
    chk("arst_need", m_if.DD_need_dstE_o, 0);
    chk("arst_stallcnt", stall_cnt, 0);
    chk("arst_bubcnt", bubble_cnt, 0);
    chk("arst_issue", issue_cnt, 0);
    #1 rst = 1'b0;
    stall = 1'b0; m_if.D_pc_i = 32'h200;
    edge1();
    chk("post_pc", m_if.DD_pc_o, 64'h200);
    chk("post_valid", m_if.DD_valid_o, 1);
    chk("post_issue", issue_cnt, 1);

    // Clear wins over a simultaneous stall event
    stall = 1'b1; clr = 1'b1;
    edge1();
    chk("clr_stallcnt", stall_cnt, 0);
    chk("clr_issue", issue_cnt, 0);
    chk("clr_pc", m_if.DD_pc_o, 64'h200);
    clr = 1'b0;
    edge1();
    chk("clr_then_stall", stall_cnt, 1);

    // 4-bit issue counter wraps after 16 issues
    s_clr = 1'b1;
    edge1();
    chk("s_clr_issue", s_issue_cnt, 0);
    s_clr = 1'b0; s_if.D_valid_i = 1'b1;
    for (int i = 0; i < 15; i++) edge1();
    chk("s_issue15", s_issue_cnt, 15);
    edge1();
    chk("s_issue_wrap", s_issue_cnt, 0);
    chk("s_valid", s_if.DD_valid_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- Decode→execute pipeline register (the "DD" stage); consumes the stall/bubble commands from the hazard unit.
- Captures decoded instruction fields every cycle.
- Holds its contents on stall; inserts a NOP-equivalent bubble on bubble.
- Its outputs feed back to the hazard unit: DD_epcode_o, DD_dstE_o and DD_need_dstE_o.
- Keeps per-stage event counters for pipeline-efficiency debug.

Parameters:
- OP_W, 11: one-hot opcode class width; equals `OP_WIDTH.
- XLEN, 32: datapath width.
- CNT_W, 32: event counter width.
- NOP_INSTR, 32'h00000013: instruction word loaded on bubble or reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- D_stall_i  in  1  hold current contents.
- D_bubble_i  in  1  load a bubble.
- cnt_clr_i  in  1  synchronous clear of event counters.
- D_valid_i  in  1  decode stage holds a real instruction.
- D_pc_i  in  XLEN  decode PC.
- D_instr_i  in  32  instruction word.
- D_epcode_i  in  OP_W  one-hot opcode class.
- D_rs1_i  in  5  source register 1 index.
- D_rs2_i  in  5  source register 2 index.
- D_dstE_i  in  5  destination register index.
- D_need_dstE_i  in  1  instruction writes dstE.
- D_imm_i  in  XLEN  decoded immediate.
- D_rs1_val_i  in  XLEN  forwarded rs1 operand.
- D_rs2_val_i  in  XLEN  forwarded rs2 operand.
- DD_valid_o  out  1  stage holds a real instruction.
- DD_pc_o  out  XLEN  registered PC.
- DD_instr_o  out  32  registered instruction word.
- DD_epcode_o  out  OP_W  registered opcode class.
- DD_rs1_o  out  5  registered rs1 index.
- DD_rs2_o  out  5  registered rs2 index.
- DD_dstE_o  out  5  registered destination index.
- DD_need_dstE_o  out  1  registered write flag.
- DD_imm_o  out  XLEN  registered immediate.
- DD_rs1_val_o  out  XLEN  registered rs1 operand.
- DD_rs2_val_o  out  XLEN  registered rs2 operand.
- stall_cnt_o  out  CNT_W  cycles held by stall.
- bubble_cnt_o  out  CNT_W  bubbles inserted.
- issue_cnt_o  out  CNT_W  valid instructions accepted.

Behaviour:
- Reset (async, rst_i=1): every output is forced immediately to its bubble value and all counters go to 0.
  - Bubble value: valid=0, pc=0, instr=NOP_INSTR, epcode=0, rs1=rs2=dstE=0, need_dstE=0, imm=0, rs1_val=rs2_val=0.
- Update on each rising edge, priority bubble > stall > load:
  - D_bubble_i=1: load the bubble value; D_stall_i is ignored.
  - D_stall_i=1, no bubble: all fields keep their value.
  - Otherwise: all fields load their D_*_i inputs. DD_valid_o loads D_valid_i.
- Gating on invalid input: if D_valid_i=0 on a load, DD_need_dstE_o and DD_epcode_o load 0 regardless of their inputs. This guarantees no false hazard detection.
- Latency: exactly 1 cycle from D_* inputs to DD_* outputs when neither stall nor bubble is asserted.
- Counters, evaluated per edge in this order:
  - cnt_clr_i=1: all three counters go to 0; no increment that cycle, even if an event occurs.
  - stall_cnt increments if D_stall_i=1 and D_bubble_i=0.
  - bubble_cnt increments if D_bubble_i=1.
  - issue_cnt increments on a load with D_valid_i=1.
  - Counters wrap modulo 2^CNT_W with no saturation.
- Reset released mid-sequence: the first rising edge after deassertion behaves as a normal cycle.
- No combinational path from any input to any output.

Test Plan:
- Load: after reset, drive D_valid_i=1, D_pc_i=0x100, D_dstE_i=5, D_need_dstE_i=1, D_epcode_i=load bit. Required: next edge shows DD_pc_o=0x100, DD_dstE_o=5, DD_valid_o=1, issue_cnt_o=1.
- Load-use stall: with 0x100 held, assert D_stall_i for 2 cycles while inputs change to pc=0x104. Required: DD_pc_o stays 0x100 and stall_cnt_o=2. After release, DD_pc_o=0x104 on the next edge.
- Bubble priority: assert D_stall_i=1 and D_bubble_i=1 together. Required: next edge gives DD_valid_o=0, DD_instr_o=0x00000013, DD_need_dstE_o=0, bubble_cnt_o+1, stall_cnt_o unchanged.
- Invalid-input gating: D_valid_i=0, D_need_dstE_i=1, D_epcode_i nonzero. Required: DD_need_dstE_o=0, DD_epcode_o=0, issue_cnt_o unchanged.
- Async reset mid-stall: pulse rst_i between clock edges. Required: outputs show bubble values and counters read 0 before the next edge. Normal loading resumes on the first edge after release.
- Counter wrap/clear: CNT_W=4 with 16 issues gives issue_cnt_o=0. Asserting cnt_clr_i together with a stall gives stall_cnt_o=0 on the next edge.
